// File: rtl/register_file_dump_pkg.sv
// Shared types and constants for the register-file debug dump path.
package register_file_dump_pkg;

    localparam int NB_BYTE         = 8;
    localparam int NB_DATA_DEFAULT = 32;
    localparam int BYTES_PER_WORD  = NB_DATA_DEFAULT / NB_BYTE;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SEND     = 3'd2,
        ST_CHECKSUM = 3'd3,
        ST_DONE     = 3'd4
    } dump_state_t;

    function automatic int bytes_per_word(input int nb_data);
        return nb_data / NB_BYTE;
    endfunction

    function automatic logic [NB_BYTE-1:0] xor_fold(input logic [NB_BYTE-1:0] acc,
                                                    input logic [NB_BYTE-1:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/dump_byte_serializer.sv
// Word-to-byte serializer: parallel load, MSB-byte-first shift-out, valid held until accepted.
module dump_byte_serializer
    import register_file_dump_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_single,
    input  logic [NB_DATA-1:0] i_load_data,
    input  logic               i_tx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_fire,
    output logic               o_last
);

    localparam int BPW    = bytes_per_word(NB_DATA);
    localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BPW - 1);

    logic [NB_DATA-1:0] r_shreg;
    logic [NB_CNT-1:0]  r_byte_cnt;
    logic               r_valid;

    assign o_tx_data  = r_shreg[NB_DATA-1 -: NB_BYTE];
    assign o_tx_valid = r_valid;
    assign o_fire     = r_valid & i_tx_ready;
    assign o_last     = (r_byte_cnt == LAST_CNT);

    // A load wins over a shift so a new word can follow the last accepted byte back-to-back.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_shreg    <= {NB_DATA{1'b0}};
            r_byte_cnt <= {NB_CNT{1'b0}};
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_shreg    <= i_load_data;
            r_byte_cnt <= i_single ? LAST_CNT : {NB_CNT{1'b0}};
            r_valid    <= 1'b1;
        end else if (o_fire) begin
            r_shreg <= r_shreg << NB_BYTE;
            if (o_last) begin
                r_byte_cnt <= {NB_CNT{1'b0}};
                r_valid    <= 1'b0;
            end else begin
                r_byte_cnt <= r_byte_cnt + NB_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/register_file_dumper.sv
// Walks every register-file address and streams each word byte-serially to the debug UART.
// Optional trailing XOR checksum byte: define REG_DUMP_CHECKSUM_EN.
module register_file_dumper
    import register_file_dump_pkg::*;
#(
    parameter int NB_ADDR   = 5,
    parameter int NB_DATA   = 32,
    parameter int RAM_DEPTH = 2**NB_ADDR
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [NB_ADDR-1:0] o_read_addr,
    input  logic [NB_DATA-1:0] i_read_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    if ((NB_DATA % NB_BYTE) != 0 || NB_DATA < NB_BYTE) begin : g_bad_width
        $error("register_file_dumper: NB_DATA must be a positive multiple of 8");
    end

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH - 1);

    dump_state_t        r_state;
    dump_state_t        w_next;
    logic [NB_ADDR-1:0] r_addr;
    logic               r_busy;
    logic               r_done;
    logic               w_load;
    logic               w_single;
    logic [NB_DATA-1:0] w_load_data;
    logic [NB_BYTE-1:0] w_tx_data;
    logic               w_fire;
    logic               w_last;

    assign o_read_addr = r_addr;
    assign o_tx_data   = w_tx_data;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] r_checksum;
    logic [NB_BYTE-1:0] w_ck_byte;

    assign w_ck_byte = xor_fold(r_checksum, w_tx_data);

    // Running XOR of every accepted byte, restarted with each dump.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_checksum <= {NB_BYTE{1'b0}};
        end else if (r_state == ST_IDLE && i_start) begin
            r_checksum <= {NB_BYTE{1'b0}};
        end else if (w_fire) begin
            r_checksum <= w_ck_byte;
        end
    end
`endif

    // State, address and status registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_addr  <= {NB_ADDR{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
            if (r_state == ST_IDLE && i_start) begin
                r_addr <= {NB_ADDR{1'b0}};
            end else if (r_state == ST_SEND && w_fire && w_last && r_addr != LAST_ADDR) begin
                r_addr <= r_addr + NB_ADDR'(1);
            end
        end
    end

    // Next-state and serializer load control; the checksum byte is loaded on the last data handshake.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_single    = 1'b0;
        w_load_data = i_read_data;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next = ST_LOAD;
                else         w_next = ST_IDLE;
            end
            ST_LOAD: begin
                w_load = 1'b1;
                w_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_fire && w_last) begin
                    if (r_addr == LAST_ADDR) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        w_next      = ST_CHECKSUM;
                        w_load      = 1'b1;
                        w_single    = 1'b1;
                        w_load_data = NB_DATA'(w_ck_byte) << (NB_DATA - NB_BYTE);
`else
                        w_next = ST_DONE;
`endif
                    end else begin
                        w_next = ST_LOAD;
                    end
                end else begin
                    w_next = ST_SEND;
                end
            end
            ST_CHECKSUM: begin
                if (w_fire) w_next = ST_DONE;
                else        w_next = ST_CHECKSUM;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    dump_byte_serializer #(
        .NB_DATA (NB_DATA)
    ) u_serializer (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_single    (w_single),
        .i_load_data (w_load_data),
        .i_tx_ready  (i_tx_ready),
        .o_tx_data   (w_tx_data),
        .o_tx_valid  (o_tx_valid),
        .o_fire      (w_fire),
        .o_last      (w_last)
    );

endmodule
